// File: rtl/rf_pkg.sv
// Shared definitions for the operand-fetch stage in front of the 16x16 register file.
// Holds the BITS/ADDR defaults, the 2-bit fetch FSM encoding and the operand-select enum.
package rf_pkg;

  localparam int unsigned BitsDefault = 16;
  localparam int unsigned AddrDefault = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StRetry = 2'd2,
    StValid = 2'd3
  } of_state_e;

  typedef enum logic [1:0] {
    SelZero = 2'd0,
    SelRf   = 2'd1,
    SelByp  = 2'd2,
    SelWb   = 2'd3
  } op_sel_e;

endpackage

// File: rtl/rf_hazard_cmp.sv
// Per-operand writeback hazard compare and operand select.
// Ports:
//   use_i       operand is actually read
//   rs_i        source register address being compared
//   wb_we_i     writeback enable
//   wb_wa_i     writeback address
//   wb_wd_i     writeback data
//   byp_vld_i   a bypass value was latched during the issue cycle
//   byp_data_i  latched bypass value
//   rf_rd_i     registered register-file read data
//   hit_o       writeback in this cycle targets the operand
//   op_o        selected operand: zero if unused, else wb > bypass > register file
module rf_hazard_cmp
  import rf_pkg::*;
#(
  parameter int unsigned BITS = BitsDefault,
  parameter int unsigned ADDR = AddrDefault
) (
  input  logic            use_i,
  input  logic [ADDR-1:0] rs_i,
  input  logic            wb_we_i,
  input  logic [ADDR-1:0] wb_wa_i,
  input  logic [BITS-1:0] wb_wd_i,
  input  logic            byp_vld_i,
  input  logic [BITS-1:0] byp_data_i,
  input  logic [BITS-1:0] rf_rd_i,
  output logic            hit_o,
  output logic [BITS-1:0] op_o
);

  op_sel_e sel;

  assign hit_o = use_i & wb_we_i & (wb_wa_i == rs_i);

  always_comb begin
    if (!use_i) begin
      sel = SelZero;
    end else if (hit_o) begin
      sel = SelWb;
    end else if (byp_vld_i) begin
      sel = SelByp;
    end else begin
      sel = SelRf;
    end
  end

  always_comb begin
    op_o = '0;
    unique case (sel)
      SelZero: op_o = '0;
      SelRf:   op_o = rf_rd_i;
      SelByp:  op_o = byp_data_i;
      SelWb:   op_o = wb_wd_i;
      default: op_o = '0;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: accepts decoded instructions, reads the register file (1-cycle
// registered read), resolves read-after-write hazards against writeback and presents
// operands to execute. One instruction per two cycles, accept -> out_valid in 2 cycles.
// Ports:
//   clk, rstn                clock, asynchronous active-low reset
//   in_valid/in_ready        instruction handshake; in_rs1/2, in_use1/2, in_rd fields
//   rf_re1/2, rf_ra1/2       register-file read enables / addresses (addresses hold when idle)
//   rf_rd1/2                 register-file read data, one cycle after the read
//   wb_we, wb_wa, wb_wd      writeback port (same write as the register file sees)
//   out_valid/out_ready      operand handshake; out_op1/2, out_rd
// Build option OPERAND_FETCH_BYPASS_EN: forward hazarded writes instead of re-reading.
// Without it a hazard sends the FSM through RETRY to repeat the read.
module operand_fetch
  import rf_pkg::*;
#(
  parameter int unsigned BITS = BitsDefault,
  parameter int unsigned ADDR = AddrDefault
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ADDR-1:0] in_rs1,
  input  logic [ADDR-1:0] in_rs2,
  input  logic            in_use1,
  input  logic            in_use2,
  input  logic [ADDR-1:0] in_rd,
  output logic            rf_re1,
  output logic            rf_re2,
  output logic [ADDR-1:0] rf_ra1,
  output logic [ADDR-1:0] rf_ra2,
  input  logic [BITS-1:0] rf_rd1,
  input  logic [BITS-1:0] rf_rd2,
  input  logic            wb_we,
  input  logic [ADDR-1:0] wb_wa,
  input  logic [BITS-1:0] wb_wd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_op1,
  output logic [BITS-1:0] out_op2,
  output logic [ADDR-1:0] out_rd
);

  of_state_e       state_q, state_d;
  logic [ADDR-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic            use1_q, use1_d, use2_q, use2_d;
  logic [BITS-1:0] out_op1_q, out_op1_d, out_op2_q, out_op2_d;
  logic [ADDR-1:0] out_rd_q, out_rd_d;

  logic            accept;
  logic            cmp_use1, cmp_use2;
  logic [ADDR-1:0] cmp_rs1, cmp_rs2;
  logic            hit1, hit2;
  logic [BITS-1:0] op1_cap, op2_cap;
  logic            byp_vld1, byp_vld2;
  logic [BITS-1:0] byp_dat1, byp_dat2;

`ifdef OPERAND_FETCH_BYPASS_EN
  logic            byp_vld1_q, byp_vld1_d, byp_vld2_q, byp_vld2_d;
  logic [BITS-1:0] byp_dat1_q, byp_dat1_d, byp_dat2_q, byp_dat2_d;
  assign byp_vld1 = byp_vld1_q;
  assign byp_vld2 = byp_vld2_q;
  assign byp_dat1 = byp_dat1_q;
  assign byp_dat2 = byp_dat2_q;
`else
  // Issue-cycle hazard seen; forces a RETRY once FETCH is reached.
  logic haz_q, haz_d;
  assign byp_vld1 = 1'b0;
  assign byp_vld2 = 1'b0;
  assign byp_dat1 = '0;
  assign byp_dat2 = '0;
`endif

  assign in_ready  = (state_q == StIdle) | ((state_q == StValid) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == StValid);
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;
  assign out_rd    = out_rd_q;

  // Reads issue on accept (fresh fields) or in RETRY (latched fields).
  assign rf_re1 = accept ? in_use1 : ((state_q == StRetry) & use1_q);
  assign rf_re2 = accept ? in_use2 : ((state_q == StRetry) & use2_q);
  assign rf_ra1 = accept ? in_rs1 : rs1_q;
  assign rf_ra2 = accept ? in_rs2 : rs2_q;

  // The comparators look at whatever is issuing this cycle, else at the latched operand.
  assign cmp_use1 = accept ? in_use1 : use1_q;
  assign cmp_use2 = accept ? in_use2 : use2_q;
  assign cmp_rs1  = accept ? in_rs1 : rs1_q;
  assign cmp_rs2  = accept ? in_rs2 : rs2_q;

  rf_hazard_cmp #(.BITS(BITS), .ADDR(ADDR)) u_cmp1 (
    .use_i      (cmp_use1),
    .rs_i       (cmp_rs1),
    .wb_we_i    (wb_we),
    .wb_wa_i    (wb_wa),
    .wb_wd_i    (wb_wd),
    .byp_vld_i  (byp_vld1),
    .byp_data_i (byp_dat1),
    .rf_rd_i    (rf_rd1),
    .hit_o      (hit1),
    .op_o       (op1_cap)
  );

  rf_hazard_cmp #(.BITS(BITS), .ADDR(ADDR)) u_cmp2 (
    .use_i      (cmp_use2),
    .rs_i       (cmp_rs2),
    .wb_we_i    (wb_we),
    .wb_wa_i    (wb_wa),
    .wb_wd_i    (wb_wd),
    .byp_vld_i  (byp_vld2),
    .byp_data_i (byp_dat2),
    .rf_rd_i    (rf_rd2),
    .hit_o      (hit2),
    .op_o       (op2_cap)
  );

  always_comb begin
    state_d   = state_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    use1_d    = use1_q;
    use2_d    = use2_q;
    rd_d      = rd_q;
    out_op1_d = out_op1_q;
    out_op2_d = out_op2_q;
    out_rd_d  = out_rd_q;
`ifdef OPERAND_FETCH_BYPASS_EN
    byp_vld1_d = byp_vld1_q;
    byp_vld2_d = byp_vld2_q;
    byp_dat1_d = byp_dat1_q;
    byp_dat2_d = byp_dat2_q;
`else
    haz_d = haz_q;
`endif

    if (accept) begin
      rs1_d  = in_rs1;
      rs2_d  = in_rs2;
      use1_d = in_use1;
      use2_d = in_use2;
      rd_d   = in_rd;
`ifdef OPERAND_FETCH_BYPASS_EN
      byp_vld1_d = hit1;
      byp_vld2_d = hit2;
      byp_dat1_d = wb_wd;
      byp_dat2_d = wb_wd;
`else
      haz_d = hit1 | hit2;
`endif
    end

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StFetch;
      end
      StFetch: begin
`ifdef OPERAND_FETCH_BYPASS_EN
        out_op1_d = op1_cap;
        out_op2_d = op2_cap;
        out_rd_d  = rd_q;
        state_d   = StValid;
`else
        if (haz_q | hit1 | hit2) begin
          state_d = StRetry;
        end else begin
          out_op1_d = op1_cap;
          out_op2_d = op2_cap;
          out_rd_d  = rd_q;
          state_d   = StValid;
        end
`endif
      end
      StRetry: begin
`ifndef OPERAND_FETCH_BYPASS_EN
        haz_d = hit1 | hit2;
`endif
        state_d = StFetch;
      end
      StValid: begin
        if (out_ready) state_d = in_valid ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use1_q    <= 1'b0;
      use2_q    <= 1'b0;
      rd_q      <= '0;
      out_op1_q <= '0;
      out_op2_q <= '0;
      out_rd_q  <= '0;
`ifdef OPERAND_FETCH_BYPASS_EN
      byp_vld1_q <= 1'b0;
      byp_vld2_q <= 1'b0;
      byp_dat1_q <= '0;
      byp_dat2_q <= '0;
`else
      haz_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      use1_q    <= use1_d;
      use2_q    <= use2_d;
      rd_q      <= rd_d;
      out_op1_q <= out_op1_d;
      out_op2_q <= out_op2_d;
      out_rd_q  <= out_rd_d;
`ifdef OPERAND_FETCH_BYPASS_EN
      byp_vld1_q <= byp_vld1_d;
      byp_vld2_q <= byp_vld2_d;
      byp_dat1_q <= byp_dat1_d;
      byp_dat2_q <= byp_dat2_d;
`else
      haz_q <= haz_d;
`endif
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: a behavioural register file plus a transaction-level
// scoreboard (one outstanding instruction; operand = register contents when it appears).
module tb_operand_fetch;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam int LatHaz = 2;
`else
  localparam int LatHaz = 4;
`endif

  logic        clk, rstn;
  logic        in_valid, in_ready;
  logic [3:0]  in_rs1, in_rs2, in_rd;
  logic        in_use1, in_use2;
  logic        rf_re1, rf_re2;
  logic [3:0]  rf_ra1, rf_ra2;
  logic [15:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [3:0]  wb_wa;
  logic [15:0] wb_wd;
  logic        out_valid, out_ready;
  logic [15:0] out_op1, out_op2;
  logic [3:0]  out_rd;

  operand_fetch dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_use1   (in_use1),
    .in_use2   (in_use2),
    .in_rd     (in_rd),
    .rf_re1    (rf_re1),
    .rf_re2    (rf_re2),
    .rf_ra1    (rf_ra1),
    .rf_ra2    (rf_ra2),
    .rf_rd1    (rf_rd1),
    .rf_rd2    (rf_rd2),
    .wb_we     (wb_we),
    .wb_wa     (wb_wa),
    .wb_wd     (wb_wd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op1   (out_op1),
    .out_op2   (out_op2),
    .out_rd    (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register file: registered read of the pre-write contents, write on posedge.
  logic [15:0] file [16];
  initial begin
    for (int i = 0; i < 16; i++) file[i] <= '0;
    rf_rd1 <= '0;
    rf_rd2 <= '0;
  end
  always @(posedge clk) begin
    if (rf_re1) rf_rd1 <= file[rf_ra1];
    if (rf_re2) rf_rd2 <= file[rf_ra2];
    if (wb_we) file[wb_wa] <= wb_wd;
  end

  // Scoreboard state, owned by the monitor below.
  bit          pend = 0;
  bit          p_u1, p_u2;
  logic [3:0]  p_rs1, p_rs2, p_rd;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          last_lat = 0;
  bit          hit_win;
  bit          prev_hold = 0;
  logic [15:0] h_op1, h_op2;
  logic [3:0]  h_rd;
  logic [3:0]  last_ra1 = '0, last_ra2 = '0;

  function automatic bit wb_hits(input bit u, input logic [3:0] rs);
    return u && wb_we && (wb_wa == rs);
  endfunction

  always @(negedge clk) begin
    bit          acc;
    logic [15:0] e1, e2;
    int          lat;
    cyc++;
    if (!rstn) begin
      pend = 0;
      prev_hold = 0;
      last_ra1 = '0;
      last_ra2 = '0;
    end else begin
      acc = in_valid && in_ready;
      if (!pend) check_eq("in_ready_idle", 32'(in_ready), 1);
      else if (out_valid) check_eq("in_ready_valid", 32'(in_ready), 32'(out_ready));
      else check_eq("in_ready_busy", 32'(in_ready), 0);

      if (acc) begin
        check_eq("re1_issue", 32'(rf_re1), 32'(in_use1));
        check_eq("re2_issue", 32'(rf_re2), 32'(in_use2));
        check_eq("ra1_issue", 32'(rf_ra1), 32'(in_rs1));
        check_eq("ra2_issue", 32'(rf_ra2), 32'(in_rs2));
      end else begin
        check_eq("ra1_hold", 32'(rf_ra1), 32'(last_ra1));
        check_eq("ra2_hold", 32'(rf_ra2), 32'(last_ra2));
        if (!pend || out_valid || !p_u1) check_eq("re1_quiet", 32'(rf_re1), 0);
        if (!pend || out_valid || !p_u2) check_eq("re2_quiet", 32'(rf_re2), 0);
      end

      if (pend && cyc == acc_cyc + 1) hit_win |= wb_hits(p_u1, p_rs1) | wb_hits(p_u2, p_rs2);

      if (out_valid) begin
        if (prev_hold) begin
          check_eq("hold_op1", 32'(out_op1), 32'(h_op1));
          check_eq("hold_op2", 32'(out_op2), 32'(h_op2));
          check_eq("hold_rd", 32'(out_rd), 32'(h_rd));
        end else if (!pend) begin
          check_eq("valid_without_issue", 32'(out_valid), 0);
        end else begin
          e1 = p_u1 ? file[p_rs1] : 16'h0;
          e2 = p_u2 ? file[p_rs2] : 16'h0;
          check_eq("op1", 32'(out_op1), 32'(e1));
          check_eq("op2", 32'(out_op2), 32'(e2));
          check_eq("rd", 32'(out_rd), 32'(p_rd));
          lat = cyc - acc_cyc;
          last_lat = lat;
`ifdef OPERAND_FETCH_BYPASS_EN
          check_eq("latency", 32'(lat), 2);
`else
          if (!hit_win) check_eq("latency", 32'(lat), 2);
          else check_eq("latency_retry_min4", 32'(lat >= 4), 1);
`endif
          h_op1 = out_op1;
          h_op2 = out_op2;
          h_rd  = out_rd;
        end
      end else if (pend && (cyc - acc_cyc > 100)) begin
        check_eq("out_valid_timeout", 32'(out_valid), 1);
        pend = 0;
      end

      prev_hold = out_valid && !out_ready;
      if (out_valid && out_ready) pend = 0;
      if (acc) begin
        pend     = 1;
        p_u1     = in_use1;
        p_u2     = in_use2;
        p_rs1    = in_rs1;
        p_rs2    = in_rs2;
        p_rd     = in_rd;
        acc_cyc  = cyc;
        hit_win  = wb_hits(in_use1, in_rs1) | wb_hits(in_use2, in_rs2);
        last_ra1 = in_rs1;
        last_ra2 = in_rs2;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wb_we = 1'b1;
    wb_wa = a;
    wb_wd = d;
    step();
    wb_we = 1'b0;
  endtask

  // Issue one instruction; w0 rides with the accept cycle, w1 with the FETCH cycle.
  task automatic issue(input logic [3:0] rs1, input logic [3:0] rs2, input bit u1, input bit u2,
                       input logic [3:0] rd, input bit w0, input logic [3:0] a0,
                       input logic [15:0] d0, input bit w1, input logic [3:0] a1,
                       input logic [15:0] d1);
    in_valid = 1'b1;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_use1 = u1;
    in_use2 = u2;
    in_rd = rd;
    wb_we = w0;
    wb_wa = a0;
    wb_wd = d0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check_eq("issue_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    wb_we = w1;
    wb_wa = a1;
    wb_wd = d1;
    step();
    wb_we = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    in_valid = 1'b0;
    in_rs1 = '0;
    in_rs2 = '0;
    in_use1 = 1'b0;
    in_use2 = 1'b0;
    in_rd = '0;
    wb_we = 1'b0;
    wb_wa = '0;
    wb_wd = '0;
    out_ready = 1'b1;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_op1", 32'(out_op1), 0);
    check_eq("rst_op2", 32'(out_op2), 0);
    check_eq("rst_rd", 32'(out_rd), 0);
    check_eq("rst_in_ready", 32'(in_ready), 1);
    #12 rstn = 1'b1;
    step();

    // Plain read after reset.
    wr(4'd3, 16'h1234);
    wr(4'd5, 16'hBEEF);
    issue(4'd3, 4'd5, 1, 1, 4'd7, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    repeat (6) step();
    check_eq("read_op1", 32'(out_op1), 32'h1234);
    check_eq("read_op2", 32'(out_op2), 32'hBEEF);
    check_eq("read_rd", 32'(out_rd), 32'd7);
    check_eq("read_lat", 32'(last_lat), 2);

    // Unused second operand reads as zero.
    issue(4'd3, 4'd5, 1, 0, 4'd2, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    repeat (6) step();
    check_eq("unused_op2", 32'(out_op2), 0);
    check_eq("unused_op1", 32'(out_op1), 32'h1234);

    // Write in the accept cycle.
    issue(4'd3, 4'd5, 1, 1, 4'd1, 1, 4'd3, 16'hAAAA, 0, 4'd0, 16'h0);
    repeat (6) step();
    check_eq("acc_wr_op1", 32'(out_op1), 32'hAAAA);
    check_eq("acc_wr_lat", 32'(last_lat), 32'(LatHaz));

    // Writes in both the accept and FETCH cycles: newest wins.
    issue(4'd6, 4'd5, 0, 1, 4'd4, 1, 4'd5, 16'h1111, 1, 4'd5, 16'h5555);
    repeat (6) step();
    check_eq("fetch_wr_op2", 32'(out_op2), 32'h5555);
    check_eq("fetch_wr_lat", 32'(last_lat), 32'(LatHaz));

    // Backpressure with a waiting instruction.
    out_ready = 1'b0;
    issue(4'd3, 4'd5, 1, 1, 4'd9, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    in_valid = 1'b1;
    in_rs1 = 4'd5;
    in_rs2 = 4'd3;
    in_use1 = 1'b1;
    in_use2 = 1'b1;
    in_rd = 4'd11;
    for (int n = 0; n < 10; n++) begin
      if (out_valid) break;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", 32'(in_ready), 0);
      check_eq("bp_op1", 32'(out_op1), 32'hAAAA);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    repeat (6) step();
    check_eq("bp_next_op1", 32'(out_op1), 32'h5555);
    check_eq("bp_next_op2", 32'(out_op2), 32'hAAAA);
    check_eq("bp_next_rd", 32'(out_rd), 32'd11);

    // Reset while in FETCH.
    in_valid = 1'b1;
    in_rs1 = 4'd3;
    in_use1 = 1'b1;
    @(negedge clk);
    step();
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check_eq("abort_out_valid", 32'(out_valid), 0);
    check_eq("abort_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    #1 rstn = 1'b1;
    step();
    check_eq("post_abort_valid", 32'(out_valid), 0);
    check_eq("post_abort_ready", 32'(in_ready), 1);
    repeat (4) step();
    check_eq("post_abort_quiet", 32'(out_valid), 0);

    // Randomised traffic with hazards concentrated on r0..r3.
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      in_rs1    = 4'($urandom_range(0, 3));
      in_rs2    = 4'($urandom_range(0, 3));
      in_use1   = ($urandom_range(0, 3) != 0);
      in_use2   = ($urandom_range(0, 3) != 0);
      in_rd     = 4'($urandom_range(0, 15));
      wb_we     = ($urandom_range(0, 1) == 1);
      wb_wa     = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(0, 3));
      wb_wd     = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid = 1'b0;
    wb_we = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
